// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile sweep controller: default sizes, the
// command op encoding and the controller state encoding.
package regfile_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_N          = 32;
   localparam int DEF_ADDR_WIDTH = $clog2(DEF_N);

   typedef enum logic [1:0] {
      OP_FILL     = 2'd0,
      OP_FILL_INC = 2'd1,
      OP_COPY     = 2'd2,
      OP_DUMP     = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_COPY,
      ST_DUMP,
      ST_DONE
   } state_e;

endpackage

// File: rtl/rf_addr_gen.sv
// Loadable address counter that wraps from N-1 to 0, with a remaining-element
// count so the controller knows when the current element is the final one.
module rf_addr_gen
   import regfile_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [ADDR_WIDTH:0]   load_len_i,
   input  logic                  step_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_o,
   output logic                  empty_o
);

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = load_addr_i;
         rem_d  = load_len_i;
      end else if (step_i && (rem_q != '0)) begin
         addr_d = (addr_q == ADDR_WIDTH'(N - 1)) ? '0 : addr_q + 1'b1;
         rem_d  = rem_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign addr_o  = addr_q;
   assign last_o  = (rem_q == (ADDR_WIDTH + 1)'(1));
   assign empty_o = (rem_q == '0);

endmodule

// File: rtl/regfile_sweep_ctrl.sv
// Bulk command initiator for one async-read / sync-write register file:
// constant fill, incrementing fill, ascending copy and streamed dump.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// FILL    | one write per cycle (constant or incrementing data)
// COPY    | read src and write dst in the same cycle, ascending
// DUMP    | stream words through a 1-deep output register
// DONE    | one-cycle done pulse, then back to IDLE
module regfile_sweep_ctrl
   import regfile_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int N          = DEF_N,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH-1:0] cmd_dst,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   input  logic [WIDTH-1:0]      cmd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] R_addr,
   output logic                  R_en,
   input  logic [WIDTH-1:0]      R_data,
   output logic [ADDR_WIDTH-1:0] W_addr,
   output logic                  W_en,
   output logic [WIDTH-1:0]      W_data
);

   localparam int LW = ADDR_WIDTH + 1;

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   op_e                   cmd_op_e;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  out_valid_q, out_valid_d;
   logic [WIDTH-1:0]      out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic [ADDR_WIDTH-1:0] r_addr_q, w_addr_q;
   logic [LW-1:0]         len_c;
   logic                  gen_load, src_step, dst_step;
   logic [ADDR_WIDTH-1:0] src_addr, dst_addr, dst_start;
   logic                  src_last, src_empty, dst_last, dst_empty;

   assign cmd_op_e  = op_e'(cmd_op);
   assign len_c     = (cmd_len > LW'(N)) ? LW'(N) : cmd_len;
   assign dst_start = (cmd_op_e == OP_COPY) ? cmd_dst : cmd_base;

   rf_addr_gen #(.N(N), .ADDR_WIDTH(ADDR_WIDTH)) u_src_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (gen_load),
      .load_addr_i (cmd_base),
      .load_len_i  (len_c),
      .step_i      (src_step),
      .addr_o      (src_addr),
      .last_o      (src_last),
      .empty_o     (src_empty)
   );

   rf_addr_gen #(.N(N), .ADDR_WIDTH(ADDR_WIDTH)) u_dst_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (gen_load),
      .load_addr_i (dst_start),
      .load_len_i  (len_c),
      .step_i      (dst_step),
      .addr_o      (dst_addr),
      .last_o      (dst_last),
      .empty_o     (dst_empty)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      gen_load    = 1'b0;
      src_step    = 1'b0;
      dst_step    = 1'b0;
      R_en        = 1'b0;
      W_en        = 1'b0;
      W_data      = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d        = cmd_op_e;
               data_d      = cmd_data;
               gen_load    = 1'b1;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (len_c == '0)                state_d = ST_DONE;
               else if (cmd_op_e == OP_COPY)   state_d = ST_COPY;
               else if (cmd_op_e == OP_DUMP)   state_d = ST_DUMP;
               else                            state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (!dst_empty) begin
               W_en     = 1'b1;
               W_data   = data_q;
               dst_step = 1'b1;
               if (op_q == OP_FILL_INC) data_d = data_q + 1'b1;
            end
            if (dst_last || dst_empty) state_d = ST_DONE;
         end
         ST_COPY: begin
            if (!dst_empty) begin
               R_en     = 1'b1;
               W_en     = 1'b1;
               W_data   = R_data;
               src_step = 1'b1;
               dst_step = 1'b1;
            end
            if (dst_last || dst_empty) state_d = ST_DONE;
         end
         ST_DUMP: begin
            // The final handshake ends the dump; otherwise refill whenever the slot frees up.
            if (out_valid_q && out_ready && out_last_q) begin
               out_valid_d = 1'b0;
               state_d     = ST_DONE;
            end else if ((!out_valid_q || out_ready) && !src_empty) begin
               R_en        = 1'b1;
               src_step    = 1'b1;
               out_valid_d = 1'b1;
               out_data_d  = R_data;
               out_last_d  = src_last;
            end else if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_FILL;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         r_addr_q    <= '0;
         w_addr_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         r_addr_q    <= R_addr;
         w_addr_q    <= W_addr;
      end
   end

   // Addresses hold their last driven value while the port is idle.
   assign R_addr    = R_en ? src_addr : r_addr_q;
   assign W_addr    = W_en ? dst_addr : w_addr_q;
   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_sweep_ctrl.sv
// Bench for regfile_sweep_ctrl with a behavioural regfile and an element-wise
// reference model of fill / copy / dump semantics.
module tb_regfile_sweep_ctrl;
   import regfile_pkg::*;

   localparam int WIDTH = 8;
   localparam int N     = 8;
   localparam int AW    = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready;
   logic [1:0]      cmd_op;
   logic [AW-1:0]   cmd_base, cmd_dst;
   logic [AW:0]     cmd_len;
   logic [WIDTH-1:0] cmd_data;
   logic            out_valid, out_ready, out_last, busy, done;
   logic [WIDTH-1:0] out_data;
   logic [AW-1:0]   R_addr, W_addr;
   logic            R_en, W_en;
   logic [WIDTH-1:0] R_data, W_data;

   logic [WIDTH-1:0] rf_mem  [N];
   logic [WIDTH-1:0] ref_mem [N];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   regfile_sweep_ctrl #(.WIDTH(WIDTH), .N(N), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_base  (cmd_base),
      .cmd_dst   (cmd_dst),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .R_addr    (R_addr),
      .R_en      (R_en),
      .R_data    (R_data),
      .W_addr    (W_addr),
      .W_en      (W_en),
      .W_data    (W_data)
   );

   // Behavioural register file: asynchronous read, synchronous write.
   assign R_data = rf_mem[R_addr];
   always @(posedge clk) if (W_en) rf_mem[W_addr] <= W_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_mem(input string tag);
      logic [63:0] a, e;
      for (int i = 0; i < N; i++) begin
         a[i*8 +: 8] = rf_mem[i];
         e[i*8 +: 8] = ref_mem[i];
      end
      check(tag, a, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one command, models it element by element, and follows it to the done pulse.
   // rdy_mode: 0 = out_ready always high, 1 = pattern 1,0,0,1,1 then high, 2 = random.
   task automatic run_cmd(input string tag, input int op, input int base, input int dst,
                          input int len, input int seed, input int rdy_mode, input bit hold_valid);
      logic [7:0]  exp_a[$];
      logic [7:0]  exp_d[$];
      logic [7:0]  d;
      logic [4:0]  pat;
      int          len_eff, a, s, nw, k, done_c, last_hs, exp_done;
      int          bad_wen, bad_ren, bad_rdy, bad_stall;
      bit          got_done, prev_stall;
      logic [7:0]  prev_data;

      pat     = 5'b11001;
      len_eff = (len > N) ? N : len;
      for (int i = 0; i < len_eff; i++) begin
         a = (base + i) % N;
         case (op)
            0: begin d = seed[7:0]; ref_mem[a] = d; end
            1: begin d = seed[7:0] + i[7:0]; ref_mem[a] = d; end
            2: begin s = a; a = (dst + i) % N; d = ref_mem[s]; ref_mem[a] = d; end
            default: d = ref_mem[a];
         endcase
         exp_a.push_back(a[7:0]);
         exp_d.push_back(d);
      end

      cmd_valid = 1'b1;
      cmd_op    = op[1:0];
      cmd_base  = base[AW-1:0];
      cmd_dst   = dst[AW-1:0];
      cmd_len   = len[AW:0];
      cmd_data  = seed[7:0];
      #1;
      check({tag, "_ready"}, cmd_ready, 1);
      tick();
      if (!hold_valid) cmd_valid = 1'b0;

      nw = 0; k = 0; done_c = -1; last_hs = -1; got_done = 0; prev_stall = 0; prev_data = '0;
      bad_wen = 0; bad_ren = 0; bad_rdy = 0; bad_stall = 0;
      for (int c = 0; c < 200 && !got_done; c++) begin
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c < 5) ? pat[c] : 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (done) begin
            got_done = 1;
            done_c   = c;
            check({tag, "_ovalid_at_done"}, out_valid, 0);
         end else begin
            if (cmd_ready) bad_rdy++;
            if (op != 3) begin
               if (W_en === 1'b1) begin
                  if (nw < len_eff) begin
                     check($sformatf("%s_waddr%0d", tag, nw), W_addr, exp_a[nw]);
                     check($sformatf("%s_wdata%0d", tag, nw), W_data, exp_d[nw]);
                  end
                  nw++;
               end
               if (W_en !== (c < len_eff)) bad_wen++;
               if (R_en !== ((op == 2) && (c < len_eff))) bad_ren++;
            end else begin
               if (W_en !== 1'b0) bad_wen++;
               if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) bad_stall++;
               if (out_valid && !out_ready && R_en !== 1'b0) bad_stall++;
               if (out_valid && out_ready) begin
                  if (k < len_eff) begin
                     check($sformatf("%s_odata%0d", tag, k), out_data, exp_d[k]);
                     check($sformatf("%s_olast%0d", tag, k), out_last, (k == len_eff - 1));
                  end
                  k++;
                  last_hs = c;
               end
               prev_stall = out_valid && !out_ready;
               prev_data  = out_data;
            end
         end
         if (!got_done) tick();
      end

      check({tag, "_done_seen"}, got_done, 1);
      exp_done = (op == 3) ? last_hs + 1 : len_eff;
      check({tag, "_done_cycle"}, done_c, exp_done);
      check({tag, "_count"}, (op == 3) ? k : nw, len_eff);
      check({tag, "_ready_busy"}, bad_rdy, 0);
      check({tag, "_wen"}, bad_wen, 0);
      if (op == 3) check({tag, "_stall"}, bad_stall, 0);
      else         check({tag, "_ren"}, bad_ren, 0);
      tick();
      check({tag, "_done_pulse"}, {done, cmd_ready, busy}, 3'b010);
      cmd_valid = 1'b0;
      check_mem({tag, "_mem"});
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_base  = '0;
      cmd_dst   = '0;
      cmd_len   = '0;
      cmd_data  = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      #2;
      check("rst_ctrl", {cmd_ready, busy, done, out_valid, out_last, R_en, W_en}, 7'b1000000);
      check("rst_data", {out_data, R_addr, W_addr, W_data}, '0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      run_cmd("init",      0, 0, 0, 8, 8'h00, 0, 0);
      run_cmd("finc_wrap", 1, 6, 0, 4, 8'h10, 0, 0);
      run_cmd("dump_wrap", 3, 6, 0, 4, 0,     0, 0);
      run_cmd("dump_stall",3, 6, 0, 3, 0,     1, 0);
      run_cmd("copy_pre",  1, 0, 0, 4, 8'hA0, 0, 0);
      run_cmd("copy_ovl",  2, 0, 1, 3, 0,     0, 0);
      run_cmd("fill_len0", 0, 3, 0, 0, 8'h99, 0, 0);
      run_cmd("fill_len9", 0, 5, 0, 9, 8'h55, 0, 0);
      run_cmd("hold_fill", 0, 2, 0, 5, 8'h3C, 0, 1);
      run_cmd("after_hold",1, 3, 0, 2, 8'h77, 0, 0);
      run_cmd("dump_all",  3, 0, 0, 8, 0,     2, 0);

      // Reset in the middle of a FILL_INC: only the first two writes may land.
      run_cmd("pre_rst",   0, 0, 0, 8, 8'hC3, 0, 0);
      ref_mem[0] = 8'h00;
      ref_mem[1] = 8'h01;
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_base  = '0;
      cmd_dst   = '0;
      cmd_len   = 4'd6;
      cmd_data  = 8'h00;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      #1;
      check("rst_mid_wen_before", {W_en, W_addr}, {1'b1, 3'd2});
      rst_n = 1'b0;
      #1;
      check("rst_mid_async", {W_en, R_en, out_valid, busy, done}, 5'b00000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_mid_nodone%0d", i), done, 0);
      end
      rst_n = 1'b1;
      tick();
      check("rst_mid_release", {cmd_ready, busy, done}, 3'b100);
      check_mem("rst_mid_mem");

      for (int r = 0; r < 24; r++) begin
         run_cmd($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), int'($urandom_range(0, N - 1)),
                 int'($urandom_range(0, N - 1)), int'($urandom_range(0, 10)),
                 int'($urandom_range(0, 255)), 2, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
